// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
//   Shared definitions for the sequential ALU:
//     - opcode width and opcode constants (ADD..CMP)
//     - handshake FSM state type
//     - iterative engine mode type
// -----------------------------------------------------------------------------
package seq_alu_pkg;

    localparam int unsigned ALU_OPW = 8;

    localparam logic [ALU_OPW-1:0] ALU_ADD = 8'h01;
    localparam logic [ALU_OPW-1:0] ALU_ADC = 8'h02;
    localparam logic [ALU_OPW-1:0] ALU_SUB = 8'h03;
    localparam logic [ALU_OPW-1:0] ALU_SUC = 8'h04;
    localparam logic [ALU_OPW-1:0] ALU_MUL = 8'h05;
    localparam logic [ALU_OPW-1:0] ALU_DIV = 8'h06;
    localparam logic [ALU_OPW-1:0] ALU_CMP = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FINISH
    } alu_state_e;

    typedef enum logic {
        MD_MUL,
        MD_DIV
    } md_mode_e;

endpackage

// File: rtl/seq_alu_muldiv.sv
// -----------------------------------------------------------------------------
// seq_alu_muldiv
//   Iterative unsigned multiply (shift-add) / divide (restoring) engine.
//   One bit per cycle, WIDTH cycles per operation.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       capture a_i/b_i/mode_i and start iterating next cycle
//   mode_i       MD_MUL or MD_DIV
//   a_i, b_i     multiplier/multiplicand or dividend/divisor
//   busy_o       iteration in progress
//   last_o       iteration counter at its final step (qualify with busy_o)
//   hi_o, lo_o   value of {hi,lo} after the step performed this cycle:
//                MUL -> {high product, low product}, DIV -> {remainder, quotient}
// -----------------------------------------------------------------------------
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  md_mode_e         mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic             run_q,  run_d;
    logic [CW-1:0]    cnt_q,  cnt_d;
    md_mode_e         mode_q, mode_d;
    logic [WIDTH-1:0] hi_q,   hi_d;
    logic [WIDTH-1:0] lo_q,   lo_d;
    logic [WIDTH-1:0] m_q,    m_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             last;

    assign last = (cnt_q == CW'(WIDTH - 1));

    // One iteration. MUL: {hi,lo} shifts right with the conditional partial
    // sum entering at the top; lo starts as the multiplier.
    // DIV: remainder shifts in the next dividend bit from lo; the quotient
    // bit shifts into lo from the bottom. The restored remainder is always
    // below the divisor, so the low WIDTH bits of the difference suffice.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        step_hi   = hi_q;
        step_lo   = lo_q;
        if (mode_q == MD_MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (div_shift >= {1'b0, m_q}) begin
            step_hi = div_shift[WIDTH-1:0] - m_q;
            step_lo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        m_d    = m_q;
        if (load_i) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            mode_d = mode_i;
            hi_d   = '0;
            lo_d   = a_i;
            m_d    = b_i;
        end else if (run_q) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            mode_q <= MD_MUL;
            hi_q   <= '0;
            lo_q   <= '0;
            m_q    <= '0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            m_q    <= m_d;
        end
    end

    // The final step's result is exported combinationally so the caller can
    // register it on the same edge that completes the iteration.
    assign busy_o = run_q;
    assign last_o = last;
    assign hi_o   = step_hi;
    assign lo_o   = step_lo;

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Multi-cycle ALU with start/busy/done handshake. ADD/ADC/SUB/SUC/CMP and
//   divide-by-zero complete in one cycle; MUL/DIV use the iterative engine
//   (WIDTH cycles). Results and flags are registered and hold between ops.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             accept op/a/b/cf when busy is low
//   op                opcode (ADD=01 ADC=02 SUB=03 SUC=04 MUL=05 DIV=06 CMP=07)
//   a, b              operands
//   cf                carry/borrow-in for ADC/SUC
//   busy              operation in flight; start is ignored
//   done              one-cycle pulse, results/flags valid from this cycle
//   acc               primary result (sum, low product, quotient)
//   c                 secondary result (high product, remainder)
//   c_flag .. ill_flag  carry/borrow, zero, overflow, divide-by-zero, illegal op
// -----------------------------------------------------------------------------
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cf,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] c,
    output logic             c_flag,
    output logic             z_flag,
    output logic             o_flag,
    output logic             dz_flag,
    output logic             ill_flag
);

    localparam logic [OPW-1:0] OP_ADD = OPW'(ALU_ADD);
    localparam logic [OPW-1:0] OP_ADC = OPW'(ALU_ADC);
    localparam logic [OPW-1:0] OP_SUB = OPW'(ALU_SUB);
    localparam logic [OPW-1:0] OP_SUC = OPW'(ALU_SUC);
    localparam logic [OPW-1:0] OP_MUL = OPW'(ALU_MUL);
    localparam logic [OPW-1:0] OP_DIV = OPW'(ALU_DIV);
    localparam logic [OPW-1:0] OP_CMP = OPW'(ALU_CMP);

    alu_state_e       state_q, state_d;
    md_mode_e         mode_q,  mode_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0] c_q,     c_d;
    logic             cfl_q,   cfl_d;
    logic             zfl_q,   zfl_d;
    logic             ofl_q,   ofl_d;
    logic             dzfl_q,  dzfl_d;
    logic             illfl_q, illfl_d;

    logic             cin;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;

    logic             eng_load;
    md_mode_e         eng_mode;
    logic             eng_busy;
    logic             eng_last;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;

    seq_alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (eng_load),
        .mode_i (eng_mode),
        .a_i    (a),
        .b_i    (b),
        .busy_o (eng_busy),
        .last_o (eng_last),
        .hi_o   (eng_hi),
        .lo_o   (eng_lo)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        c_d      = c_q;
        cfl_d    = cfl_q;
        zfl_d    = zfl_q;
        ofl_d    = ofl_q;
        dzfl_d   = dzfl_q;
        illfl_d  = illfl_q;
        eng_load = 1'b0;
        eng_mode = MD_MUL;

        cin     = cf & ((op == OP_ADC) | (op == OP_SUC));
        add_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sub_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FINISH;
                    case (op)
                        OP_ADD, OP_ADC: begin
                            acc_d   = add_ext[WIDTH-1:0];
                            cfl_d   = add_ext[WIDTH];
                            zfl_d   = (add_ext[WIDTH-1:0] == '0);
                            ofl_d   = (a[WIDTH-1] == b[WIDTH-1]) &&
                                      (add_ext[WIDTH-1] != a[WIDTH-1]);
                            dzfl_d  = 1'b0;
                            illfl_d = 1'b0;
                        end
                        OP_SUB, OP_SUC: begin
                            acc_d   = sub_ext[WIDTH-1:0];
                            cfl_d   = sub_ext[WIDTH];
                            zfl_d   = (sub_ext[WIDTH-1:0] == '0);
                            ofl_d   = (a[WIDTH-1] != b[WIDTH-1]) &&
                                      (sub_ext[WIDTH-1] != a[WIDTH-1]);
                            dzfl_d  = 1'b0;
                            illfl_d = 1'b0;
                        end
                        OP_MUL: begin
                            // Flags stay put until the product lands.
                            state_d  = ST_RUN;
                            mode_d   = MD_MUL;
                            eng_load = 1'b1;
                            eng_mode = MD_MUL;
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                acc_d   = '1;
                                c_d     = a;
                                cfl_d   = 1'b0;
                                zfl_d   = 1'b0;
                                ofl_d   = 1'b0;
                                dzfl_d  = 1'b1;
                                illfl_d = 1'b0;
                            end else begin
                                state_d  = ST_RUN;
                                mode_d   = MD_DIV;
                                eng_load = 1'b1;
                                eng_mode = MD_DIV;
                            end
                        end
                        OP_CMP: begin
                            zfl_d   = (a == b);
                            cfl_d   = (a < b);
                            ofl_d   = (a > b);
                            dzfl_d  = 1'b0;
                            illfl_d = 1'b0;
                        end
                        default: begin
                            dzfl_d  = 1'b0;
                            illfl_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (eng_busy && eng_last) begin
                    state_d = ST_FINISH;
                    acc_d   = eng_lo;
                    c_d     = eng_hi;
                    ofl_d   = 1'b0;
                    dzfl_d  = 1'b0;
                    illfl_d = 1'b0;
                    if (mode_q == MD_MUL) begin
                        zfl_d = ({eng_hi, eng_lo} == '0);
                        cfl_d = (eng_hi != '0);
                    end else begin
                        zfl_d = (eng_lo == '0);
                        cfl_d = 1'b0;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MD_MUL;
            acc_q   <= '0;
            c_q     <= '0;
            cfl_q   <= 1'b0;
            zfl_q   <= 1'b0;
            ofl_q   <= 1'b0;
            dzfl_q  <= 1'b0;
            illfl_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            cfl_q   <= cfl_d;
            zfl_q   <= zfl_d;
            ofl_q   <= ofl_d;
            dzfl_q  <= dzfl_d;
            illfl_q <= illfl_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FINISH);
    assign acc      = acc_q;
    assign c        = c_q;
    assign c_flag   = cfl_q;
    assign z_flag   = zfl_q;
    assign o_flag   = ofl_q;
    assign dz_flag  = dzfl_q;
    assign ill_flag = illfl_q;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//   Self-checking bench for seq_alu (WIDTH=16). Expected results are queued
//   when an op is issued and compared when done pulses.
//   Flags are compared packed as {c_flag, z_flag, o_flag, dz_flag, ill_flag}.
// -----------------------------------------------------------------------------
module tb_seq_alu;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    op = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cf = 1'b0;
    logic          busy, done;
    logic [W-1:0]  acc, c;
    logic          c_flag, z_flag, o_flag, dz_flag, ill_flag;

    seq_alu #(
        .WIDTH (W),
        .OPW   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .cf       (cf),
        .busy     (busy),
        .done     (done),
        .acc      (acc),
        .c        (c),
        .c_flag   (c_flag),
        .z_flag   (z_flag),
        .o_flag   (o_flag),
        .dz_flag  (dz_flag),
        .ill_flag (ill_flag)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    typedef struct {
        string       tag;
        logic [15:0] eacc;
        logic [15:0] ec;
        logic [4:0]  efl;
        int unsigned lat;
        int unsigned cyc0;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [7:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cf;
        logic [15:0] eacc;
        logic [15:0] ec;
        logic [4:0]  efl;
        int unsigned lat;
    } vec_t;
    localparam int unsigned NT = 19;
    vec_t tbl[NT];

    // Reference state for ops that leave acc/c/flags unchanged.
    logic [15:0] m_acc = '0;
    logic [15:0] m_c   = '0;
    logic [4:0]  m_fl  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] flags();
        return {c_flag, z_flag, o_flag, dz_flag, ill_flag};
    endfunction

    // Scoreboard consumer.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && done) begin
                if (sbq.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk({e.tag, ".acc"},   32'(acc),          32'(e.eacc));
                    chk({e.tag, ".c"},     32'(c),            32'(e.ec));
                    chk({e.tag, ".flags"}, 32'(flags()),      32'(e.efl));
                    chk({e.tag, ".lat"},   32'(cyc - e.cyc0), 32'(e.lat));
                end
            end
        end
    end

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input string tag, input logic [7:0] o, input logic [15:0] aa,
                         input logic [15:0] bb, input logic cc, input logic [15:0] eacc,
                         input logic [15:0] ec, input logic [4:0] efl, input int unsigned lat);
        sb_t e;
        wait_idle();
        e.tag  = tag;
        e.eacc = eacc;
        e.ec   = ec;
        e.efl  = efl;
        e.lat  = lat;
        e.cyc0 = cyc;
        sbq.push_back(e);
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        cf    = cc;
        @(negedge clk);
        // Scramble inputs while busy; the DUT must have latched them.
        start = 1'b0;
        op    = 8'($urandom);
        a     = 16'($urandom);
        b     = 16'($urandom);
        cf    = 1'($urandom);
        m_acc = eacc;
        m_c   = ec;
        m_fl  = efl;
    endtask

    task automatic rand_op(input int unsigned idx);
        logic [7:0]  o;
        logic [15:0] aa, bb;
        logic        cc, cin;
        logic [15:0] eacc, ec;
        logic        fc, fz, fo, fdz, fill;
        logic [31:0] p;
        int          s;
        int unsigned lat;
        o  = 8'($urandom_range(1, 8));
        if (o == 8'd8) o = 8'hA5;
        aa = 16'($urandom);
        bb = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
        cc = 1'($urandom);
        eacc = m_acc;
        ec   = m_c;
        {fc, fz, fo, fdz, fill} = m_fl;
        fdz  = 1'b0;
        fill = 1'b0;
        lat  = 1;
        case (o)
            8'd1, 8'd2: begin
                cin  = (o == 8'd2) ? cc : 1'b0;
                p    = 32'(aa) + 32'(bb) + 32'(cin);
                eacc = p[15:0];
                fc   = p[16];
                fz   = (eacc == 16'h0000);
                s    = int'($signed(aa)) + int'($signed(bb)) + int'(cin);
                fo   = (s > 32767) || (s < -32768);
            end
            8'd3, 8'd4: begin
                cin  = (o == 8'd4) ? cc : 1'b0;
                eacc = aa - bb - 16'(cin);
                fc   = (32'(aa) < 32'(bb) + 32'(cin));
                fz   = (eacc == 16'h0000);
                s    = int'($signed(aa)) - int'($signed(bb)) - int'(cin);
                fo   = (s > 32767) || (s < -32768);
            end
            8'd5: begin
                p    = 32'(aa) * 32'(bb);
                eacc = p[15:0];
                ec   = p[31:16];
                fz   = (p == 32'd0);
                fc   = (ec != 16'h0000);
                fo   = 1'b0;
                lat  = W + 1;
            end
            8'd6: begin
                if (bb == 16'h0000) begin
                    eacc = 16'hFFFF;
                    ec   = aa;
                    fdz  = 1'b1;
                    fz   = 1'b0;
                    fc   = 1'b0;
                    fo   = 1'b0;
                end else begin
                    eacc = aa / bb;
                    ec   = aa % bb;
                    fz   = (eacc == 16'h0000);
                    fc   = 1'b0;
                    fo   = 1'b0;
                    lat  = W + 1;
                end
            end
            8'd7: begin
                fz = (aa == bb);
                fc = (aa < bb);
                fo = (aa > bb);
            end
            default: fill = 1'b1;
        endcase
        issue($sformatf("r%0d_op%02h", idx, o), o, aa, bb, cc, eacc, ec,
              {fc, fz, fo, fdz, fill}, lat);
    endtask

    initial begin
        int unsigned nb;
        int unsigned n;

        //            op     a         b        cf    acc       c         cZoDI     lat
        tbl[0]  = '{8'h01, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h0000, 5'b00100, 1};
        tbl[1]  = '{8'h03, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 5'b10000, 1};
        tbl[2]  = '{8'h02, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 16'h0000, 5'b11000, 1};
        tbl[3]  = '{8'h05, 16'h1234, 16'h5678, 1'b0, 16'h0060, 16'h0626, 5'b10000, 17};
        tbl[4]  = '{8'h06, 16'd1000, 16'd7,    1'b0, 16'h008E, 16'h0006, 5'b00000, 17};
        tbl[5]  = '{8'h06, 16'h00AB, 16'h0000, 1'b0, 16'hFFFF, 16'h00AB, 5'b00010, 1};
        tbl[6]  = '{8'h07, 16'd5,    16'd9,    1'b0, 16'hFFFF, 16'h00AB, 5'b10000, 1};
        tbl[7]  = '{8'h07, 16'd9,    16'd5,    1'b0, 16'hFFFF, 16'h00AB, 5'b00100, 1};
        tbl[8]  = '{8'h07, 16'd7,    16'd7,    1'b0, 16'hFFFF, 16'h00AB, 5'b01000, 1};
        tbl[9]  = '{8'hFF, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 16'h00AB, 5'b01001, 1};
        tbl[10] = '{8'h04, 16'h0005, 16'h0003, 1'b1, 16'h0001, 16'h00AB, 5'b00000, 1};
        tbl[11] = '{8'h03, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 16'h00AB, 5'b00100, 1};
        tbl[12] = '{8'h05, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'hFFFE, 5'b10000, 17};
        tbl[13] = '{8'h05, 16'h0000, 16'h1234, 1'b0, 16'h0000, 16'h0000, 5'b01000, 17};
        tbl[14] = '{8'h06, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 5'b00000, 17};
        tbl[15] = '{8'h06, 16'h0003, 16'h0010, 1'b0, 16'h0000, 16'h0003, 5'b01000, 17};
        tbl[16] = '{8'h00, 16'h1111, 16'h2222, 1'b0, 16'h0000, 16'h0003, 5'b01001, 1};
        tbl[17] = '{8'h01, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0003, 5'b11000, 1};
        tbl[18] = '{8'h04, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h0003, 5'b10000, 1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.busy",  32'(busy),    32'd0);
        chk("rst.done",  32'(done),    32'd0);
        chk("rst.acc",   32'(acc),     32'd0);
        chk("rst.c",     32'(c),       32'd0);
        chk("rst.flags", 32'(flags()), 32'd0);

        for (int i = 0; i < int'(NT); i++) begin
            issue($sformatf("t%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cf,
                  tbl[i].eacc, tbl[i].ec, tbl[i].efl, tbl[i].lat);
        end

        // MUL with an ADD start pulsed mid-run: the ADD must be dropped.
        issue("mul_drop", 8'h05, 16'h1234, 16'h5678, 1'b0, 16'h0060, 16'h0626, 5'b10000, 17);
        nb = 0;
        while (busy && nb < 100) begin
            nb++;
            if (nb == 5) begin
                start = 1'b1;
                op    = 8'h01;
                a     = 16'h0001;
                b     = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("mul_busy_cycles", 32'(nb), 32'd17);

        // Reset in the middle of a MUL: no done, everything cleared.
        wait_idle();
        start = 1'b1;
        op    = 8'h05;
        a     = 16'h1234;
        b     = 16'h5678;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 8'h01;
        a     = 16'h0002;
        b     = 16'h0002;
        chk("abort.busy_mid", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.busy",  32'(busy),    32'd0);
        chk("abort.done",  32'(done),    32'd0);
        chk("abort.acc",   32'(acc),     32'd0);
        chk("abort.c",     32'(c),       32'd0);
        chk("abort.flags", 32'(flags()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = '0;
        m_c   = '0;
        m_fl  = '0;
        repeat (20) @(negedge clk);
        chk("abort.idle", 32'(busy), 32'd0);
        issue("post_rst_add", 8'h01, 16'h0002, 16'h0003, 1'b0, 16'h0005, 16'h0000, 5'b00000, 1);

        for (int unsigned i = 0; i < 40; i++) begin
            rand_op(i);
        end

        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (sbq.size() != 0) chk("drain", 32'(sbq.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
